tdm_mux8_serializer: RTL and testbench

//  Transmit-side counterpart of the 1-to-8 demux: accepts an 8-bit channel word and

---
 rtl/tdm_mux8_serializer_pkg.sv | 17 +
 rtl/tdm_sel_counter.sv | 30 +++
 rtl/tdm_mux8_serializer.sv | 120 ++++++++++++
 tb/tb_tdm_mux8_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux8_serializer_pkg.sv
// Shared constants for the TDM 8-channel serializer and its matching demux.
// Holds the channel geometry, the FSM encoding and the frame-boundary indices.
package tdm_mux8_serializer_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Channel indices that mark the frame boundaries on the link.
    localparam int FIRST_SEL = 0;
    localparam int LAST_SEL  = N_CH - 1;

endpackage

// File: rtl/tdm_sel_counter.sv
// Wrapping channel-index counter for the TDM serializer.
// N_CH is a power of two, so the natural SEL_W-bit rollover gives the wrap.
module tdm_sel_counter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);

    logic [SEL_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == SEL_W'(N_CH - 1));

endmodule

// File: rtl/tdm_mux8_serializer.sv
// Serializes an N_CH-bit channel word onto one line, LSB first, tagging each
// bit with its channel index; back-to-back frames run without a gap cycle.
module tdm_mux8_serializer #(
    parameter int N_CH  = tdm_mux8_serializer_pkg::N_CH,
    parameter int SEL_W = tdm_mux8_serializer_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [N_CH-1:0]  din,
    output logic             ready,
    output logic             out,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             frame_start,
    output logic             done
);

    import tdm_mux8_serializer_pkg::*;

    state_t           state_reg;
    state_t           state_next;
    logic [N_CH-1:0]  hold_reg;
    logic [SEL_W-1:0] cnt;
    logic             last;
    logic             fire;
    logic             accept;

    logic             out_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             valid_reg;
    logic             frame_start_reg;
    logic             done_reg;

    tdm_sel_counter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (fire & ~accept),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ready opens in the last beat of a frame so the next word can follow
    // immediately; load itself never feeds back into ready.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        fire       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    fire = 1'b1;
                    if (last) begin
                        ready      = 1'b1;
                        state_next = load ? SHIFT : IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = load & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else if (accept) begin
            hold_reg <= din;
        end
    end

    // The mux reads the old hold_reg on a back-to-back edge, so the last bit
    // of the outgoing frame is emitted while the new word is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg         <= 1'b0;
            sel_reg         <= '0;
            valid_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            valid_reg       <= fire;
            frame_start_reg <= fire & (cnt == SEL_W'(FIRST_SEL));
            done_reg        <= fire & last;
            if (fire) begin
                out_reg <= hold_reg[cnt];
                sel_reg <= cnt;
            end
        end
    end

    assign out         = out_reg;
    assign sel         = sel_reg;
    assign valid       = valid_reg;
    assign frame_start = frame_start_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_tdm_mux8_serializer.sv
// Directed bench for the TDM serializer: a scoreboard queue holds the expected
// beats of every accepted frame and each valid output beat is popped and compared.
module tb_tdm_mux8_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] din;
    logic       ready;
    logic       out;
    logic [2:0] sel;
    logic       valid;
    logic       frame_start;
    logic       done;

    typedef struct packed {
        logic       o;
        logic [2:0] s;
        logic       fs;
        logic       dn;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    tdm_mux8_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .din         (din),
        .ready       (ready),
        .out         (out),
        .sel         (sel),
        .valid       (valid),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] w);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.o  = w[i];
            b.s  = 3'(i);
            b.fs = (i == 0);
            b.dn = (i == 7);
            sb.push_back(b);
        end
    endtask

    task automatic tick();
        beat_t b;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("valid_without_expected_beat", {7'b0, valid}, 8'd0);
            end else begin
                b = sb.pop_front();
                chk("out", {7'b0, out}, {7'b0, b.o});
                chk("sel", {5'b0, sel}, {5'b0, b.s});
                chk("frame_start", {7'b0, frame_start}, {7'b0, b.fs});
                chk("done", {7'b0, done}, {7'b0, b.dn});
                $display("beat sel=%0d out=%0b fs=%0b done=%0b", sel, out, frame_start, done);
            end
        end else begin
            chk("frame_start_idle", {7'b0, frame_start}, 8'd0);
            chk("done_idle", {7'b0, done}, 8'd0);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out"}, {7'b0, out}, 8'd0);
        chk({tag, "_sel"}, {5'b0, sel}, 8'd0);
        chk({tag, "_valid"}, {7'b0, valid}, 8'd0);
        chk({tag, "_fs"}, {7'b0, frame_start}, 8'd0);
        chk({tag, "_done"}, {7'b0, done}, 8'd0);
        chk({tag, "_ready"}, {7'b0, ready}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        din   = 8'h00;

        // 1. asynchronous reset before any clock edge, then 3 idle cycles
        #2 rst_n = 1'b0;
        #1;
        check_cleared("reset_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cleared("reset_idle");
        end

        // 2. basic frame 8'hA6 -> 0,1,1,0,0,1,0,1
        en   = 1'b1;
        din  = 8'hA6;
        load = 1'b1;
        chk("t2_ready_idle", {7'b0, ready}, 8'd1);
        push_frame(8'hA6);
        tick();
        load = 1'b0;
        din  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_valid", {7'b0, valid}, 8'd1);
            chk("t2_ready", {7'b0, ready}, (i >= 6) ? 8'd1 : 8'd0);
        end
        tick();
        chk("t2_valid_after", {7'b0, valid}, 8'd0);
        chk("t2_sb_empty", 8'(sb.size()), 8'd0);

        // 3. stall two cycles after sel=3
        din  = 8'h3C;
        load = 1'b1;
        push_frame(8'h3C);
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_stall_valid", {7'b0, valid}, 8'd0);
            chk("t3_stall_sel", {5'b0, sel}, 8'd3);
            chk("t3_stall_out", {7'b0, out}, 8'd1);
            chk("t3_stall_ready", {7'b0, ready}, 8'd0);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_resume_valid", {7'b0, valid}, 8'd1);
        end
        tick();
        chk("t3_valid_after", {7'b0, valid}, 8'd0);
        chk("t3_sb_empty", 8'(sb.size()), 8'd0);

        // 4. back-to-back: 8'hFF then 8'h00 loaded during the last beat
        din  = 8'hFF;
        load = 1'b1;
        push_frame(8'hFF);
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("t4_ready_last_beat", {7'b0, ready}, 8'd1);
        din  = 8'h00;
        load = 1'b1;
        push_frame(8'h00);
        tick();
        load = 1'b0;
        chk("t4_valid_beat8", {7'b0, valid}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_valid_continuous", {7'b0, valid}, 8'd1);
        end
        tick();
        chk("t4_valid_after", {7'b0, valid}, 8'd0);
        chk("t4_sb_empty", 8'(sb.size()), 8'd0);

        // 5. load while not ready is ignored
        din  = 8'h5A;
        load = 1'b1;
        push_frame(8'h5A);
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_ready_busy", {7'b0, ready}, 8'd0);
        din  = 8'h0F;
        load = 1'b1;
        tick();
        load = 1'b0;
        din  = 8'h00;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_extra_frame", {7'b0, valid}, 8'd0);
        end
        chk("t5_sb_empty", 8'(sb.size()), 8'd0);

        // 6. reset at sel=5 discards the frame; then 8'h81
        din  = 8'hC3;
        load = 1'b1;
        push_frame(8'hC3);
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_sel_before_reset", {5'b0, sel}, 8'd5);
        #2 rst_n = 1'b0;
        #1;
        check_cleared("t6_reset_async");
        sb.delete();
        @(posedge clk);
        #1;
        check_cleared("t6_reset_held");
        rst_n = 1'b1;
        din   = 8'h81;
        load  = 1'b1;
        push_frame(8'h81);
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_valid", {7'b0, valid}, 8'd1);
        end
        tick();
        chk("t6_valid_after", {7'b0, valid}, 8'd0);
        chk("t6_sb_empty", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
